// File: rtl/gpio_arb_pkg.sv
// ============================================================================
//  Module   : gpio_arb_pkg
//  Brief    : Shared types for the GPIO port arbiter (ops, FSM states, widths).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_arb_pkg;

    typedef enum logic [1:0] {
        OP_RD      = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_WR_DIR  = 2'b10,
        OP_NOP     = 2'b11
    } gpio_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } arb_state_e;

    // Wide enough for RD_WAIT up to 15.
    localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/gpio_rr_picker.sv
// ============================================================================
//  Module   : gpio_rr_picker
//  Brief    : Combinational round-robin pick: first set request at or after ptr.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_rr_picker
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        logic [IDX_W:0] cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpio_port_arbiter.sv
// ============================================================================
//  Module   : gpio_port_arbiter
//  Brief    : Round-robin sharing of one GPIO core port with shadowed data/dir.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_port_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int WIDTH_PORT = 8,
    parameter int NUM_REQ    = 3,
    parameter int RD_WAIT    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [2*NUM_REQ-1:0]          op_i,
    input  logic [NUM_REQ*WIDTH_PORT-1:0] wdata_i,
    input  logic [NUM_REQ*WIDTH_PORT-1:0] wmask_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic [WIDTH_PORT-1:0]         rdata_o,
    output logic                          busy_o,
    output logic                          gpio_we_o,
    output logic [WIDTH_PORT-1:0]         gpio_wdata_o,
    output logic [WIDTH_PORT-1:0]         gpio_dir_o,
    input  logic [WIDTH_PORT-1:0]         gpio_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [1:0]            op_arr    [NUM_REQ];
    logic [WIDTH_PORT-1:0] wdata_arr [NUM_REQ];
    logic [WIDTH_PORT-1:0] wmask_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign op_arr[g]    = op_i[2*g +: 2];
        assign wdata_arr[g] = wdata_i[WIDTH_PORT*g +: WIDTH_PORT];
        assign wmask_arr[g] = wmask_i[WIDTH_PORT*g +: WIDTH_PORT];
    end

    arb_state_e            state_q;
    gpio_op_e              op_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      ptr_d;
    logic [IDX_W-1:0]      idx_q;
    logic [WIDTH_PORT-1:0] d_q;
    logic [WIDTH_PORT-1:0] m_q;
    logic [WIDTH_PORT-1:0] shadow_data_q;
    logic [WIDTH_PORT-1:0] shadow_dir_q;
    logic [WIDTH_PORT-1:0] rdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic                  busy_q;
    logic                  we_q;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    ack_d;

    gpio_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    assign ack_d = ONE_HOT0 << idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NOP;
            ptr_q         <= '0;
            idx_q         <= '0;
            d_q           <= '0;
            m_q           <= '0;
            shadow_data_q <= '0;
            shadow_dir_q  <= '0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            busy_q        <= 1'b0;
            we_q          <= 1'b0;
        end else begin
            ack_q <= '0;
            we_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        op_q    <= gpio_op_e'(op_arr[pick_idx]);
                        d_q     <= wdata_arr[pick_idx];
                        m_q     <= wmask_arr[pick_idx];
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_WR_DATA: begin
                            shadow_data_q <= (shadow_data_q & ~m_q) | (d_q & m_q);
                            we_q          <= 1'b1;
                            ack_q         <= ack_d;
                            state_q       <= ST_RESP;
                        end
                        OP_WR_DIR: begin
                            shadow_dir_q <= (shadow_dir_q & ~m_q) | (d_q & m_q);
                            ack_q        <= ack_d;
                            state_q      <= ST_RESP;
                        end
                        OP_RD: begin
                            cnt_q   <= CNT_W'(RD_WAIT - 1);
                            state_q <= ST_WAIT;
                        end
                        default: begin
                            ack_q   <= ack_d;
                            state_q <= ST_RESP;
                        end
                    endcase
                end
                ST_WAIT: begin
                    // Settle time lets the core's input synchronizer catch up.
                    if (cnt_q == '0) begin
                        rdata_q <= gpio_rdata_i;
                        ack_q   <= ack_d;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_o        = ack_q;
    assign rdata_o      = rdata_q;
    assign busy_o       = busy_q;
    assign gpio_we_o    = we_q;
    assign gpio_wdata_o = shadow_data_q;
    assign gpio_dir_o   = shadow_dir_q;

endmodule

`default_nettype wire
